// File: rtl/merge_sort_unit_if.sv
// Handshake/data bundle for merge_sort_unit.
// master drives start/data_in, slave returns the sorted array.
interface merge_sort_unit_if #(
   parameter int N = 8,
   parameter int W = 8
);
   logic         start;
   logic [W-1:0] data_in  [0:N-1];
   logic [W-1:0] data_out [0:N-1];
   logic         busy;
   logic         done;

   modport master (
      output start,
      output data_in,
      input  data_out,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  data_in,
      output data_out,
      output busy,
      output done
   );
endinterface

// File: rtl/merge_sort_unit.sv
// Bottom-up ping-pong merge sorter for N unsigned W-bit words.
// Define MERGE_SORT_DESC_EN for descending output order.
module merge_sort_unit #(
   parameter int N = 8,
   parameter int W = 8
) (
   input  logic             clk,
   input  logic             rst,
   merge_sort_unit_if.slave bus
);
   localparam int LG = (N > 1) ? $clog2(N) : 1;
   localparam int CW = LG + 1;
   localparam int L  = (N / 2 > 0) ? N / 2 : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_MERGE,
      S_DONE
   } state_t;

   state_t        state_q;
   logic [W-1:0]  buf_a_q [0:N-1];
   logic [W-1:0]  buf_b_q [0:N-1];
   logic [W-1:0]  out_q   [0:N-1];
   logic [W-1:0]  src     [0:N-1];
   logic [W-1:0]  dst_d   [0:N-1];
   logic [CW-1:0] li_q    [0:L-1];
   logic [CW-1:0] ri_q    [0:L-1];
   logic [CW-1:0] li_d    [0:L-1];
   logic [CW-1:0] ri_d    [0:L-1];
   logic [CW-1:0] w_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] last_cnt;
   logic          src_q;
   logic          busy_q;
   logic          done_q;

   int            base;
   logic          lx;
   logic          rx;
   logic          le;
   logic          take;
   logic [W-1:0]  lv;
   logic [W-1:0]  rv;

   function automatic logic [LG-1:0] ix(input int v);
      return v[LG-1:0];
   endfunction

   assign last_cnt     = (w_q << 1) - CW'(1);
   assign bus.data_out = out_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

   // One merge step per lane: pick the head of the left or right run
   always_comb begin
      base = 0;
      lx   = 1'b0;
      rx   = 1'b0;
      le   = 1'b0;
      take = 1'b0;
      lv   = '0;
      rv   = '0;
      for (int i = 0; i < N; i++) begin
         src[i]   = src_q ? buf_b_q[i] : buf_a_q[i];
         dst_d[i] = src_q ? buf_a_q[i] : buf_b_q[i];
      end
      for (int l = 0; l < L; l++) begin
         li_d[l] = li_q[l];
         ri_d[l] = ri_q[l];
      end
      for (int l = 0; l < L; l++) begin
         base = l * 2 * int'(w_q);
         if (base < N) begin
            lx = (li_q[l] == w_q);
            rx = (ri_q[l] == w_q);
            lv = src[ix(base + int'(li_q[l]))];
            rv = src[ix(base + int'(w_q) + int'(ri_q[l]))];
`ifdef MERGE_SORT_DESC_EN
            le = (lv >= rv);
`else
            le = (lv <= rv);
`endif
            take = !lx && (rx || le);
            dst_d[ix(base + int'(li_q[l]) + int'(ri_q[l]))] =
               take ? lv : rv;
            if (take) li_d[l] = li_q[l] + CW'(1);
            else      ri_d[l] = ri_q[l] + CW'(1);
         end
      end
   end

   // Sequencer: capture, merge passes, publish result with done pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         w_q     <= '0;
         cnt_q   <= '0;
         src_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < N; i++) begin
            buf_a_q[i] <= '0;
            buf_b_q[i] <= '0;
            out_q[i]   <= '0;
         end
         for (int l = 0; l < L; l++) begin
            li_q[l] <= '0;
            ri_q[l] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  for (int i = 0; i < N; i++)
                     buf_a_q[i] <= bus.data_in[i];
                  busy_q  <= 1'b1;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               w_q     <= CW'(1);
               cnt_q   <= '0;
               src_q   <= 1'b0;
               for (int l = 0; l < L; l++) begin
                  li_q[l] <= '0;
                  ri_q[l] <= '0;
               end
               state_q <= S_MERGE;
            end
            S_MERGE: begin
               for (int i = 0; i < N; i++) begin
                  if (src_q) buf_a_q[i] <= dst_d[i];
                  else       buf_b_q[i] <= dst_d[i];
               end
               if (cnt_q == last_cnt) begin
                  src_q <= ~src_q;
                  w_q   <= w_q << 1;
                  cnt_q <= '0;
                  for (int l = 0; l < L; l++) begin
                     li_q[l] <= '0;
                     ri_q[l] <= '0;
                  end
                  if (w_q == CW'(L)) state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
                  for (int l = 0; l < L; l++) begin
                     li_q[l] <= li_d[l];
                     ri_q[l] <= ri_d[l];
                  end
               end
            end
            S_DONE: begin
               for (int i = 0; i < N; i++)
                  out_q[i] <= src[i];
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_merge_sort_unit.sv
// Directed bench for merge_sort_unit (ascending build).
// Latency, held output, restart, abort by reset.
module tb_merge_sort_unit;
   localparam int N = 8;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   lat;
   bit   held;
   bit   seen;

   merge_sort_unit_if #(.N(N), .W(W)) bus ();

   merge_sort_unit #(.N(N), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] pack_out();
      logic [63:0] p;
      p = '0;
      for (int i = 0; i < N; i++) p[63-8*i -: 8] = bus.data_out[i];
      return p;
   endfunction

   task automatic apply(input logic [63:0] v);
      for (int i = 0; i < N; i++) bus.data_in[i] = v[63-8*i -: 8];
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input logic [63:0] hold,
                            output int l, output bit h);
      l = -1;
      h = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            l = k;
            break;
         end
         if (pack_out() !== hold) h = 1'b0;
      end
   endtask

   task automatic sort(input string tag, input logic [63:0] din,
                       input logic [63:0] exp, input logic [63:0] hold);
      apply(din);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      apply(64'hA5C3_0FF0_5A3C_F00F);
      chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
      wait_done(hold, lat, held);
      chk({tag, "_lat"}, 64'(lat), 64'd16);
      chk({tag, "_data"}, pack_out(), exp);
      chk({tag, "_hold"}, 64'(held), 64'd1);
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, 64'(bus.done), 64'd0);
      chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      bus.start = 1'b0;
      apply(64'h1122_3344_5566_7788);
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data", pack_out(), 64'h0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      rst = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
      end
      chk("idle_quiet", 64'(seen), 64'd0);
      chk("idle_data", pack_out(), 64'h0);

      sort("s1", "cadbabab", "aaabbbcd", 64'h0);
      sort("s2", "babacdaf", "aaabbcdf", "aaabbbcd");
      sort("s3", {24'h0, "twoab"}, {24'h0, "abotw"}, "aaabbcdf");

      apply({16'h0, "abcdef"});
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done({24'h0, "abotw"}, lat, held);
      chk("s4_lat", 64'(lat), 64'd11);
      chk("s4_data", pack_out(), {16'h0, "abcdef"});
      chk("s4_hold", 64'(held), 64'd1);

      apply({8'h0, "hgfedcb"});
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      wait_done({16'h0, "abcdef"}, lat, held);
      chk("s5_lat", 64'(lat), 64'd16);
      chk("s5_data", pack_out(), {8'h0, "bcdefgh"});
      @(posedge clk);
      #1;
      chk("s5_restart", 64'(bus.busy), 64'd1);
      bus.start = 1'b0;
      wait_done({8'h0, "bcdefgh"}, lat, held);
      chk("s6_lat", 64'(lat), 64'd16);
      chk("s6_data", pack_out(), {8'h0, "bcdefgh"});

      apply("cadbabab");
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("abort_data", pack_out(), 64'h0);
      chk("abort_busy", 64'(bus.busy), 64'd0);
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) seen = 1'b1;
      end
      chk("abort_done", 64'(seen), 64'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      sort("s7", "babacdaf", "aaabbcdf", 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
